// File: rtl/mem_pkg.sv
// Shared memory-map constants and responder state encoding for the multicycle CPU.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRespond
  } mem_state_e;

  localparam logic [1:0] OFS_SW     = 2'd0;
  localparam logic [1:0] OFS_LED    = 2'd1;
  localparam logic [1:0] OFS_CNT_LO = 2'd2;
  localparam logic [1:0] OFS_CNT_HI = 2'd3;

endpackage

// File: rtl/mem_spram.sv
// Synchronous single-port word RAM: one-cycle read latency, write-first.
module mem_spram #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side target for CPU fetch/load/store: word RAM plus a 4-word I/O window
// (switches, LEDs, free-running cycle counter with high-half shadow).
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DEPTH_LOG2 = 10,
  parameter int unsigned       LATENCY    = 2,
  parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(16'hFF00)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic [15:0]       io_sw,
  output logic [15:0]       io_led
);

  localparam logic [2:0] WAIT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  mem_state_e        state_q;
  logic [2:0]        wait_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       cnt_q;
  logic [15:0]       shadow_q;
  logic [DATA_W-1:0] io_rdata_q;
  logic              ram_rd_q;

  logic              commit;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [ADDR_W-1:0] io_ofs;
  logic [1:0]        ofs;
  logic              ram_hit;
  logic              io_hit;
  logic              c_err;
  logic [DATA_W-1:0] io_rd;
  logic [DATA_W-1:0] ram_rdata;

  // The request being committed comes straight from the bus when LATENCY is 1.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state_q == StIdle) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
    commit  = ((state_q == StIdle) && req_valid && (LATENCY == 1)) ||
              ((state_q == StAccess) && (wait_q == 3'd0));
    ram_hit = (c_addr >> DEPTH_LOG2) == '0;
    io_ofs  = c_addr - IO_BASE;
    io_hit  = io_ofs < ADDR_W'(4);
    ofs     = io_ofs[1:0];
    c_err   = !ram_hit && (!io_hit || (c_we && (ofs != OFS_LED)));
    io_rd   = '0;
    case (ofs)
      OFS_SW:     io_rd = DATA_W'(io_sw);
      OFS_LED:    io_rd = DATA_W'(io_led);
      OFS_CNT_LO: io_rd = DATA_W'(cnt_q[15:0]);
      OFS_CNT_HI: io_rd = DATA_W'(shadow_q);
      default:    io_rd = '0;
    endcase
  end

  // Reset gates the enable so a store on the reset edge never lands.
  mem_spram #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .en   (commit && ram_hit && !reset),
    .we   (c_we),
    .addr (c_addr[DEPTH_LOG2-1:0]),
    .wdata(c_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_q     <= 3'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 32'd0;
      shadow_q   <= 16'd0;
      io_rdata_q <= '0;
      ram_rd_q   <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      io_led     <= 16'd0;
    end else begin
      cnt_q     <= cnt_q + 32'd1;
      rsp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wait_q    <= WAIT_INIT;
            state_q   <= StAccess;
            req_ready <= 1'b0;
          end
        end
        StAccess: begin
          if (wait_q != 3'd0) wait_q <= wait_q - 3'd1;
        end
        StRespond: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
          rsp_err   <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
      // Commit edge: all side effects and read sampling happen entering StRespond.
      if (commit) begin
        state_q    <= StRespond;
        req_ready  <= 1'b0;
        rsp_valid  <= 1'b1;
        rsp_err    <= c_err;
        ram_rd_q   <= ram_hit && !c_we;
        io_rdata_q <= (c_err || c_we || ram_hit) ? '0 : io_rd;
        if (!c_err && !ram_hit && c_we && (ofs == OFS_LED)) io_led <= c_wdata[15:0];
        if (!c_err && !ram_hit && !c_we && (ofs == OFS_CNT_LO)) shadow_q <= cnt_q[31:16];
      end
    end
  end

  assign rsp_rdata = !rsp_valid ? '0 : (ram_rd_q ? ram_rdata : io_rdata_q);

endmodule
